// File: rtl/wght_mc_ctrl.sv
// Weight multicast controller: filters GLB weight words by column/row tag and
// queues them in a small FIFO that feeds the addressed PE row one-hot.
module wght_mc_ctrl #(
   parameter int DATA_W  = 64,
   parameter int NUM_ROW = 12,
   parameter int DEPTH   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [15:0]        i_expected,
   input  logic [3:0]         i_col_id,
   input  logic               i_wght_valid,
   input  logic [7:0]         i_wght_tag,
   input  logic [DATA_W-1:0]  i_wght_data,
   output logic [DATA_W-1:0]  o_pe_wght_data,
   output logic [NUM_ROW-1:0] o_pe_wght_valid,
   input  logic [NUM_ROW-1:0] i_pe_wght_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_ovf,
   output logic [7:0]         o_drop_cnt,
   output logic [15:0]        o_deliv_cnt
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state, state_nx;
   logic [15:0]       expected_q;
   logic [3:0]        col_id_q;
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [3:0]        mem_row  [DEPTH];
   logic [AW:0]       wptr, rptr;
   logic              empty, full;
   logic              start_ok, leave_run, flush;
   logic              row_in_range, accept, push, pop, ovf_evt, drop_evt;
   logic [3:0]        row_tag, col_tag, head_row;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign row_tag  = i_wght_tag[7:4];
   assign col_tag  = i_wght_tag[3:0];
   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head_row = mem_row[rptr[AW-1:0]];

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (i_start) state_nx = S_RUN;
         S_RUN:   if (o_deliv_cnt == expected_q) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign o_busy    = (state == S_RUN);
   assign o_done    = (state == S_DONE);
   assign start_ok  = (state == S_IDLE) && i_start;
   assign leave_run = (state == S_RUN) && (state_nx != S_RUN);
   assign flush     = start_ok || leave_run;

   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign row_in_range = (row_tag != 4'd0) && (int'(row_tag) <= NUM_ROW);
   assign accept   = (state == S_RUN) && i_wght_valid && (col_tag == col_id_q) && row_in_range;
   assign pop      = |(o_pe_wght_valid & i_pe_wght_ready);
   assign push     = accept && (!full || pop);
   assign ovf_evt  = accept && full && !pop;
   assign drop_evt = (i_wght_valid && !accept) || ovf_evt;

   always_comb begin
      o_pe_wght_valid = '0;
      o_pe_wght_data  = '0;
      if (!empty) begin
         o_pe_wght_data = mem_data[rptr[AW-1:0]];
         for (int r = 0; r < NUM_ROW; r++)
            o_pe_wght_valid[r] = (head_row == 4'(r));
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         expected_q  <= '0;
         col_id_q    <= '0;
         wptr        <= '0;
         rptr        <= '0;
         o_ovf       <= 1'b0;
         o_drop_cnt  <= '0;
         o_deliv_cnt <= '0;
      end else begin
         state <= state_nx;
         if (start_ok) begin
            expected_q <= i_expected;
            col_id_q   <= i_col_id;
         end
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
         end
         if (start_ok) begin
            o_ovf       <= 1'b0;
            o_drop_cnt  <= '0;
            o_deliv_cnt <= '0;
         end else begin
            if (ovf_evt)  o_ovf       <= 1'b1;
            if (drop_evt) o_drop_cnt  <= sat_inc8(o_drop_cnt);
            if (pop)      o_deliv_cnt <= o_deliv_cnt + 16'd1;
         end
      end
   end

   // Storage is qualified by the pointers, so it carries no reset.
   always_ff @(posedge i_clk) begin
      if (push && !flush) begin
         mem_data[wptr[AW-1:0]] <= i_wght_data;
         mem_row[wptr[AW-1:0]]  <= row_tag - 4'd1;
      end
   end

endmodule

// File: tb/tb_wght_mc_ctrl.sv
// Scoreboard bench for wght_mc_ctrl: directed tag streams push expected head
// entries; a negedge monitor compares the PE-side output against the queue.
module tb_wght_mc_ctrl;

   localparam int DATA_W  = 64;
   localparam int NUM_ROW = 12;
   localparam int DEPTH   = 4;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [15:0]        expected;
   logic [3:0]         col_id;
   logic               wght_valid;
   logic [7:0]         wght_tag;
   logic [DATA_W-1:0]  wght_data;
   logic [DATA_W-1:0]  pe_data;
   logic [NUM_ROW-1:0] pe_valid;
   logic [NUM_ROW-1:0] pe_ready;
   logic               busy, done, ovf;
   logic [7:0]         drop_cnt;
   logic [15:0]        deliv_cnt;

   typedef struct {
      logic [3:0]        row;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 0;

   wght_mc_ctrl #(.DATA_W(DATA_W), .NUM_ROW(NUM_ROW), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_expected(expected),
      .i_col_id(col_id), .i_wght_valid(wght_valid), .i_wght_tag(wght_tag),
      .i_wght_data(wght_data), .o_pe_wght_data(pe_data), .o_pe_wght_valid(pe_valid),
      .i_pe_wght_ready(pe_ready), .o_busy(busy), .o_done(done), .o_ovf(ovf),
      .o_drop_cnt(drop_cnt), .o_deliv_cnt(deliv_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: head of the scoreboard must be presented; it retires on handshake.
   always @(negedge clk) begin
      logic [NUM_ROW-1:0] exp_v;
      logic [DATA_W-1:0]  exp_d;
      if (mon_en) begin
         exp_v = '0;
         exp_d = '0;
         if (q.size() > 0) begin
            exp_v = NUM_ROW'(1) << q[0].row;
            exp_d = q[0].data;
         end
         chk("pe_valid", 64'(pe_valid), 64'(exp_v));
         chk("pe_data", pe_data, exp_d);
         if (q.size() > 0 && (pe_ready & exp_v) != '0) void'(q.pop_front());
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_pass(input logic [15:0] n, input logic [3:0] col);
      start    = 1'b1;
      expected = n;
      col_id   = col;
      tick();
      start    = 1'b0;
   endtask

   task automatic send(input logic [7:0] tag, input logic [63:0] d, input bit acc);
      exp_t e;
      wght_valid = 1'b1;
      wght_tag   = tag;
      wght_data  = d;
      @(posedge clk);
      if (acc) begin
         e.row  = tag[7:4] - 4'd1;
         e.data = d;
         q.push_back(e);
      end
      #1;
      wght_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk({name, "_done_seen"}, 64'(done), 64'd1);
      chk({name, "_q_drained"}, 64'(q.size()), 64'd0);
      tick();
      chk({name, "_done_pulse"}, 64'(done), 64'd0);
      chk({name, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; expected = '0; col_id = '0;
      wght_valid = 1'b0; wght_tag = '0; wght_data = '0; pe_ready = '0;
      repeat (3) tick();
      chk("rst_valid", 64'(pe_valid), 0);
      chk("rst_data", pe_data, 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_ovf", 64'(ovf), 0);
      chk("rst_drop", 64'(drop_cnt), 0);
      chk("rst_deliv", 64'(deliv_cnt), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // Nominal: one word per row 1..4, all rows ready.
      pe_ready = '1;
      start_pass(16'd4, 4'd1);
      chk("nom_busy", 64'(busy), 1);
      send(8'h11, 64'hA1, 1);
      send(8'h21, 64'hA2, 1);
      send(8'h31, 64'hA3, 1);
      send(8'h41, 64'hA4, 1);
      wait_done("nom");
      chk("nom_deliv", 64'(deliv_cnt), 4);
      chk("nom_drop", 64'(drop_cnt), 0);

      // Backpressure: six words into a 4-deep FIFO, two overflow.
      pe_ready = '0;
      start_pass(16'd4, 4'd1);
      for (int i = 0; i < 6; i++) send(8'h11, 64'hB1 + 64'(i), i < 4);
      chk("ovf_flag", 64'(ovf), 1);
      chk("ovf_drop", 64'(drop_cnt), 2);
      pe_ready = 12'hFFE;
      repeat (2) tick();
      chk("ovf_hold_deliv", 64'(deliv_cnt), 0);
      pe_ready = '1;
      wait_done("ovf");
      chk("ovf_deliv", 64'(deliv_cnt), 4);
      chk("ovf_sticky", 64'(ovf), 1);

      // Full FIFO with push and pop in the same cycle.
      pe_ready = '0;
      start_pass(16'd5, 4'd1);
      chk("pp_ovf_clr", 64'(ovf), 0);
      for (int i = 0; i < 4; i++) send(8'h11, 64'hC1 + 64'(i), 1);
      pe_ready = 12'h001;
      send(8'h11, 64'hC5, 1);
      pe_ready = '0;
      chk("pp_no_ovf", 64'(ovf), 0);
      chk("pp_deliv", 64'(deliv_cnt), 1);
      send(8'h11, 64'hC6, 0);
      chk("pp_full_ovf", 64'(ovf), 1);
      chk("pp_drop", 64'(drop_cnt), 1);
      pe_ready = '1;
      wait_done("pp");
      chk("pp_deliv_end", 64'(deliv_cnt), 5);

      // Filtering: wrong column, row 0, row 13 dropped; row 12 accepted.
      start_pass(16'd1, 4'd1);
      send(8'h12, 64'hD1, 0);
      start = 1'b1;
      expected = 16'd0;
      send(8'h01, 64'hD2, 0);
      start = 1'b0;
      send(8'hD1, 64'hD3, 0);
      chk("flt_drop", 64'(drop_cnt), 3);
      chk("flt_busy", 64'(busy), 1);
      send(8'hC1, 64'hD4, 1);
      wait_done("flt");
      chk("flt_deliv", 64'(deliv_cnt), 1);
      chk("flt_drop_end", 64'(drop_cnt), 3);

      // Reset mid-pass with two words queued.
      pe_ready = '0;
      start_pass(16'd8, 4'd1);
      send(8'h15, 64'hE0, 0);
      send(8'h11, 64'hE1, 1);
      send(8'h21, 64'hE2, 1);
      chk("mid_drop", 64'(drop_cnt), 1);
      rst_n = 1'b0;
      @(posedge clk);
      q.delete();
      #1;
      chk("mr_valid", 64'(pe_valid), 0);
      chk("mr_data", pe_data, 0);
      chk("mr_busy", 64'(busy), 0);
      chk("mr_ovf", 64'(ovf), 0);
      chk("mr_drop", 64'(drop_cnt), 0);
      chk("mr_deliv", 64'(deliv_cnt), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("mr_no_done", 64'(done), 0);
         chk("mr_stay_idle", 64'(busy), 0);
         tick();
      end

      // Idle drops, counter saturation, then zero-length pass.
      send(8'h11, 64'hF1, 0);
      send(8'h11, 64'hF2, 0);
      chk("idle_drop", 64'(drop_cnt), 2);
      for (int i = 0; i < 300; i++) send(8'hFF, 64'(i), 0);
      chk("drop_sat", 64'(drop_cnt), 255);
      start_pass(16'd0, 4'd1);
      chk("z_busy", 64'(busy), 1);
      chk("z_done0", 64'(done), 0);
      chk("z_drop_clr", 64'(drop_cnt), 0);
      tick();
      chk("z_done", 64'(done), 1);
      chk("z_busy_off", 64'(busy), 0);
      tick();
      chk("z_done_end", 64'(done), 0);
      chk("z_deliv", 64'(deliv_cnt), 0);

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
